// File: rtl/round_control_pkg.sv
// Shared game definitions: state codes, field widths and settings payload.
package round_control_pkg;

  localparam int unsigned SCORE_W     = 7;
  localparam int unsigned MAX_PLAYERS = 4;
  localparam int unsigned ID_W        = 2;
  localparam int unsigned PC_W        = 3;
  localparam int unsigned QN_W        = 4;
  localparam int unsigned PTS_W       = 4;
  localparam int unsigned TIME_W      = 7;
  localparam int unsigned SUM_W       = SCORE_W + 1;
  localparam int unsigned SCORES_W    = MAX_PLAYERS * SCORE_W;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OPEN   = 3'd1,
    ANSWER = 3'd2,
    RESULT = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]    player_count;
    logic [QN_W-1:0]    question_count;
    logic [TIME_W-1:0]  answer_time;
    logic [SCORE_W-1:0] win_score;
    logic [PTS_W-1:0]   success_score;
    logic [PTS_W-1:0]   fail_score;
  } settings_t;

  // Force the player count into the legal 2..MAX_PLAYERS range.
  function automatic logic [PC_W-1:0] clamp_players(input logic [PC_W-1:0] pc);
    if (pc < PC_W'(2)) return PC_W'(2);
    if (pc > PC_W'(MAX_PLAYERS)) return PC_W'(MAX_PLAYERS);
    return pc;
  endfunction

endpackage

// File: rtl/round_control_if.sv
// Game settings, host controls, player buttons and round status.
interface round_control_if;
  import round_control_pkg::*;

  logic                tick_1hz;
  logic [PC_W-1:0]     player_count;
  logic [QN_W-1:0]     question_count;
  logic [TIME_W-1:0]   answer_time;
  logic [SCORE_W-1:0]  win_score;
  logic [PTS_W-1:0]    success_score;
  logic [PTS_W-1:0]    fail_score;
  logic                start;
  logic                next;
  logic                judge_ok;
  logic                judge_fail;
  logic [MAX_PLAYERS-1:0] buzz;

  logic [2:0]          state;
  logic                grant_valid;
  logic [ID_W-1:0]     grant_id;
  logic [TIME_W-1:0]   time_left;
  logic [QN_W-1:0]     question_no;
  logic [SCORES_W-1:0] scores;
  logic                game_over;
  logic [ID_W-1:0]     champion;

  modport master (
    output tick_1hz, player_count, question_count, answer_time, win_score,
           success_score, fail_score, start, next, judge_ok, judge_fail, buzz,
    input  state, grant_valid, grant_id, time_left, question_no, scores,
           game_over, champion
  );

  modport slave (
    input  tick_1hz, player_count, question_count, answer_time, win_score,
           success_score, fail_score, start, next, judge_ok, judge_fail, buzz,
    output state, grant_valid, grant_id, time_left, question_no, scores,
           game_over, champion
  );

endinterface

// File: rtl/round_control_rr_arbiter4.sv
// Four-way round-robin picker; the player after 'pointer' has top priority.
module rr_arbiter4
  import round_control_pkg::*;
(
  input  logic [MAX_PLAYERS-1:0] req,
  input  logic [ID_W-1:0]        pointer,
  output logic [ID_W-1:0]        gnt_id,
  output logic                   gnt_valid
);

  // Scan lowest to highest priority so the highest-priority hit wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int k = MAX_PLAYERS; k >= 1; k--) begin
      if (req[pointer + ID_W'(k)]) begin
        gnt_valid = 1'b1;
        gnt_id    = pointer + ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/round_control.sv
// Quiz round controller: buzz arbitration, answer timer, scoring, game end.
module round_control
  import round_control_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  round_control_if.slave bus
);

  state_t state_q, state_d;
  settings_t cfg_q, cfg_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TIME_W-1:0]     time_left_q, time_left_d;
  logic [QN_W-1:0]       question_no_q, question_no_d;
  logic [MAX_PLAYERS-1:0][SCORE_W-1:0] scores_q, scores_d, scores_upd_c;
  logic                  game_over_q, game_over_d;
  logic [ID_W-1:0]       champion_q, champion_d;
  logic                  verdict_ok_q, verdict_ok_d;
  logic [MAX_PLAYERS-1:0] buzz_prev_q;

  logic [MAX_PLAYERS-1:0] active_mask_c, buzz_rise_c;
  logic                  arb_valid_c;
  logic [ID_W-1:0]       arb_id_c, leader_c;
  logic [SUM_W-1:0]      sum_c;
  logic [SCORE_W-1:0]    cur_score_c, fail_pts_c, new_score_c;
  logic [QN_W-1:0]       q_next_c, q_limit_c;

  // Rising button edges from players taking part in this game.
  always_comb begin
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      active_mask_c[i] = (PC_W'(i) < cfg_q.player_count);
    end
    buzz_rise_c = bus.buzz & ~buzz_prev_q & active_mask_c;
  end

  rr_arbiter4 u_arb (
    .req       (buzz_rise_c),
    .pointer   (rr_ptr_q),
    .gnt_id    (arb_id_c),
    .gnt_valid (arb_valid_c)
  );

  // Verdict applied to the granted player, with saturation and floor.
  always_comb begin
    cur_score_c = scores_q[grant_id_q];
    fail_pts_c  = SCORE_W'(cfg_q.fail_score);
    sum_c       = SUM_W'(cur_score_c) + SUM_W'(cfg_q.success_score);
    if (verdict_ok_q) begin
      new_score_c = sum_c[SCORE_W] ? SCORE_MAX : sum_c[SCORE_W-1:0];
    end else begin
      new_score_c = (cur_score_c >= fail_pts_c) ? (cur_score_c - fail_pts_c) : '0;
    end
  end

  // Post-update scoreboard, leading player (ties to lowest index), question limit.
  always_comb begin
    scores_upd_c             = scores_q;
    scores_upd_c[grant_id_q] = new_score_c;
    leader_c                 = '0;
    for (int i = 1; i < MAX_PLAYERS; i++) begin
      if (scores_upd_c[i] > scores_upd_c[leader_c]) leader_c = ID_W'(i);
    end
    q_next_c  = question_no_q + QN_W'(1);
    q_limit_c = (cfg_q.question_count == '0) ? QN_W'(1) : cfg_q.question_count;
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d       = state_q;
    cfg_d         = cfg_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    time_left_d   = time_left_q;
    question_no_d = question_no_q;
    scores_d      = scores_q;
    game_over_d   = game_over_q;
    champion_d    = champion_q;
    verdict_ok_d  = verdict_ok_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          cfg_d.player_count   = clamp_players(bus.player_count);
          cfg_d.question_count = bus.question_count;
          cfg_d.answer_time    = bus.answer_time;
          cfg_d.win_score      = bus.win_score;
          cfg_d.success_score  = bus.success_score;
          cfg_d.fail_score     = bus.fail_score;
          scores_d             = '0;
          question_no_d        = '0;
          game_over_d          = 1'b0;
          champion_d           = '0;
          state_d              = OPEN;
        end
      end
      OPEN: begin
        if (arb_valid_c) begin
          grant_valid_d = 1'b1;
          grant_id_d    = arb_id_c;
          rr_ptr_d      = arb_id_c;
          time_left_d   = cfg_q.answer_time;
          state_d       = ANSWER;
        end
      end
      ANSWER: begin
        if (bus.judge_fail || bus.judge_ok) begin
          verdict_ok_d = !bus.judge_fail;
          time_left_d  = '0;
          state_d      = RESULT;
        end else if (bus.tick_1hz) begin
          if (time_left_q == '0) begin
            verdict_ok_d = 1'b0;
            state_d      = RESULT;
          end else begin
            time_left_d = time_left_q - TIME_W'(1);
          end
        end
      end
      RESULT: begin
        scores_d      = scores_upd_c;
        question_no_d = q_next_c;
        grant_valid_d = 1'b0;
        if (new_score_c >= cfg_q.win_score) begin
          champion_d  = grant_id_q;
          game_over_d = 1'b1;
          state_d     = DONE;
        end else if (q_next_c == q_limit_c) begin
          champion_d  = leader_c;
          game_over_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.next) state_d = OPEN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; button history tracks every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cfg_q         <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= ID_W'(3);
      time_left_q   <= '0;
      question_no_q <= '0;
      scores_q      <= '0;
      game_over_q   <= 1'b0;
      champion_q    <= '0;
      verdict_ok_q  <= 1'b0;
      buzz_prev_q   <= '0;
    end else begin
      state_q       <= state_d;
      cfg_q         <= cfg_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      time_left_q   <= time_left_d;
      question_no_q <= question_no_d;
      scores_q      <= scores_d;
      game_over_q   <= game_over_d;
      champion_q    <= champion_d;
      verdict_ok_q  <= verdict_ok_d;
      buzz_prev_q   <= bus.buzz;
    end
  end

  assign bus.state       = state_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.time_left   = time_left_q;
  assign bus.question_no = question_no_q;
  assign bus.scores      = scores_q;
  assign bus.game_over   = game_over_q;
  assign bus.champion    = champion_q;

endmodule

// File: tb/tb_round_control.sv
// Bench for round_control: directed games, random play, asynchronous reset.
module tb_round_control;

  localparam int S_IDLE = 0, S_OPEN = 1, S_ANSWER = 2, S_RESULT = 3, S_WAIT = 4, S_DONE = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  round_control_if bus ();

  round_control dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int step = 0;
  logic [3:0] cur_buzz = 4'b0;

  // Reference model of the game as seen at the outputs.
  int m_st, m_gv, m_gid, m_tl, m_qno, m_over, m_champ, m_last, m_ok;
  int m_pc, m_qc, m_at, m_win, m_s, m_f;
  int m_sc[4];
  logic [3:0] m_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_gv = 0; m_gid = 0; m_tl = 0; m_qno = 0; m_over = 0;
    m_champ = 0; m_last = 3; m_ok = 0; m_prev = 4'b0;
    for (int i = 0; i < 4; i++) m_sc[i] = 0;
  endtask

  task automatic model_step(input bit st, input bit nx, input bit ok, input bit fl,
                            input bit tk, input logic [3:0] bz);
    logic [3:0] rises;
    bit found;
    int idx, best;
    rises = bz & ~m_prev;
    for (int i = 0; i < 4; i++) if (i >= m_pc) rises[i] = 1'b0;
    m_prev = bz;
    case (m_st)
      S_IDLE, S_DONE: if (st) begin
        m_pc  = (int'(bus.player_count) < 2) ? 2 : (int'(bus.player_count) > 4) ? 4 : int'(bus.player_count);
        m_qc  = (bus.question_count == 0) ? 1 : int'(bus.question_count);
        m_at  = int'(bus.answer_time);
        m_win = int'(bus.win_score);
        m_s   = int'(bus.success_score);
        m_f   = int'(bus.fail_score);
        for (int i = 0; i < 4; i++) m_sc[i] = 0;
        m_qno = 0; m_over = 0; m_champ = 0; m_st = S_OPEN;
      end
      S_OPEN: if (rises != 4'b0) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          idx = (m_last + k) % 4;
          if (!found && rises[idx]) begin found = 1'b1; m_gid = idx; end
        end
        m_last = m_gid; m_gv = 1; m_tl = m_at; m_st = S_ANSWER;
      end
      S_ANSWER: begin
        if (fl) begin m_ok = 0; m_tl = 0; m_st = S_RESULT; end
        else if (ok) begin m_ok = 1; m_tl = 0; m_st = S_RESULT; end
        else if (tk) begin
          if (m_tl == 0) begin m_ok = 0; m_st = S_RESULT; end
          else m_tl = m_tl - 1;
        end
      end
      S_RESULT: begin
        if (m_ok) m_sc[m_gid] = (m_sc[m_gid] + m_s > 127) ? 127 : m_sc[m_gid] + m_s;
        else      m_sc[m_gid] = (m_sc[m_gid] - m_f < 0) ? 0 : m_sc[m_gid] - m_f;
        m_qno = m_qno + 1; m_gv = 0;
        if (m_sc[m_gid] >= m_win) begin m_champ = m_gid; m_over = 1; m_st = S_DONE; end
        else if (m_qno == m_qc) begin
          best = 0;
          for (int i = 1; i < 4; i++) if (m_sc[i] > m_sc[best]) best = i;
          m_champ = best; m_over = 1; m_st = S_DONE;
        end else m_st = S_WAIT;
      end
      S_WAIT: if (nx) m_st = S_OPEN;
      default: ;
    endcase
  endtask

  task automatic check_all();
    logic [27:0] es;
    for (int i = 0; i < 4; i++) es[7*i +: 7] = 7'(m_sc[i]);
    chk("state", bus.state, m_st);
    chk("grant_valid", bus.grant_valid, m_gv);
    chk("grant_id", bus.grant_id, m_gid);
    chk("time_left", bus.time_left, m_tl);
    chk("question_no", bus.question_no, m_qno);
    chk("scores", bus.scores, es);
    chk("game_over", bus.game_over, m_over);
    chk("champion", bus.champion, m_champ);
  endtask

  // One clock with the given pulses; buzz is a level held afterwards.
  task automatic cyc(input bit st, input bit nx, input bit ok, input bit fl,
                     input bit tk, input logic [3:0] bz);
    bus.start = st; bus.next = nx; bus.judge_ok = ok; bus.judge_fail = fl;
    bus.tick_1hz = tk; bus.buzz = bz; cur_buzz = bz;
    model_step(st, nx, ok, fl, tk, bz);
    @(posedge clk); #1;
    step++;
    bus.start = 0; bus.next = 0; bus.judge_ok = 0; bus.judge_fail = 0; bus.tick_1hz = 0;
    check_all();
  endtask

  task automatic idle();              cyc(0, 0, 0, 0, 0, cur_buzz); endtask
  task automatic do_start();          cyc(1, 0, 0, 0, 0, cur_buzz); endtask
  task automatic do_next();           cyc(0, 1, 0, 0, 0, cur_buzz); endtask
  task automatic do_ok();             cyc(0, 0, 1, 0, 0, cur_buzz); endtask
  task automatic do_tick();           cyc(0, 0, 0, 0, 1, cur_buzz); endtask
  task automatic press(input logic [3:0] b); cyc(0, 0, 0, 0, 0, b); endtask

  task automatic settings(input int pc, input int qc, input int at, input int win,
                          input int s, input int f);
    bus.player_count = 3'(pc); bus.question_count = 4'(qc); bus.answer_time = 7'(at);
    bus.win_score = 7'(win); bus.success_score = 4'(s); bus.fail_score = 4'(f);
  endtask

  // Asynchronous reset asserted and checked between clock edges.
  task automatic async_reset();
    bus.buzz = 4'b0; cur_buzz = 4'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    step++;
    check_all();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    step++;
    check_all();
  endtask

  initial begin
    bus.start = 0; bus.next = 0; bus.judge_ok = 0; bus.judge_fail = 0;
    bus.tick_1hz = 0; bus.buzz = 4'b0;
    settings(0, 0, 0, 0, 0, 0);
    m_pc = 2; m_qc = 1; m_at = 0; m_win = 0; m_s = 0; m_f = 0;
    model_reset();
    #1 rst = 1'b1;
    #2 check_all();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check_all();

    // Four players, two questions: simultaneous buzzes and a tied finish.
    settings(4, 2, 5, 100, 1, 1);
    do_start();
    chk("b_open", bus.state, S_OPEN);
    press(4'b1001);
    chk("b_first_grant", bus.grant_id, 0);
    press(4'b0000);
    do_ok(); idle();
    chk("b_score0", bus.scores[6:0], 1);
    do_next();
    press(4'b1001);
    chk("b_second_grant", bus.grant_id, 3);
    press(4'b0000);
    do_ok(); idle();
    chk("b_done", bus.state, S_DONE);
    chk("b_tie_champion", bus.champion, 0);
    chk("b_game_over", bus.game_over, 1);

    // Two players: inactive button, timeout with floor, win by score.
    settings(2, 5, 10, 3, 1, 1);
    do_start();
    press(4'b1000);
    chk("a_inactive_ignored", bus.state, S_OPEN);
    press(4'b0000);
    press(4'b0001);
    chk("a_grant", bus.grant_id, 0);
    chk("a_time", bus.time_left, 10);
    chk("a_answer", bus.state, S_ANSWER);
    settings(4, 1, 1, 1, 9, 9);
    press(4'b0000);
    do_ok(); idle();
    chk("a_score0", bus.scores[6:0], 1);
    chk("a_wait", bus.state, S_WAIT);
    do_next();
    press(4'b0010);
    press(4'b0000);
    for (int i = 0; i < 10; i++) do_tick();
    chk("a_time_zero", bus.time_left, 0);
    do_tick();
    chk("a_timeout", bus.state, S_RESULT);
    idle();
    chk("a_floor", bus.scores[13:7], 0);
    for (int q = 0; q < 2; q++) begin
      do_next(); press(4'b0001); press(4'b0000); do_ok(); idle();
    end
    chk("a_win_done", bus.state, S_DONE);
    chk("a_win_champion", bus.champion, 0);
    do_next();
    chk("a_next_ignored", bus.state, S_DONE);

    // Score saturation at 127.
    settings(2, 15, 10, 127, 15, 1);
    do_start();
    for (int q = 0; q < 9; q++) begin
      if (q > 0) do_next();
      press(4'b0001); press(4'b0000); do_ok(); idle();
    end
    chk("sat_score", bus.scores[6:0], 127);

    // Random play with settings churning every cycle.
    for (int n = 0; n < 1500; n++) begin
      settings($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(1, 8), $urandom_range(0, 5), $urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) cur_buzz = 4'($urandom);
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, cur_buzz);
    end

    // Reset asserted mid-answer.
    async_reset();
    settings(3, 4, 6, 50, 2, 1);
    do_start();
    press(4'b0100);
    chk("r_answer", bus.state, S_ANSWER);
    async_reset();
    chk("r_state", bus.state, S_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/round_control.md
ROUND_CONTROL -- requirements
Module: round_control

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick_1hz  in  1  one-cycle pulse per second
- player_count  in  3  settings value, legal 2..4
- question_count  in  4  questions per game
- answer_time  in  7  seconds allowed per answer
- win_score  in  7  score that ends the game
- success_score  in  4  points added on correct answer
- fail_score  in  4  points removed on wrong answer or timeout
- start  in  1  pulse; begin game
- next  in  1  pulse; open next question
- judge_ok, judge_fail  in  1 each  host verdict pulses
- buzz  in  4  debounced player buttons, level, bit i = player i
- state  out  3  FSM state code
- grant_valid  out  1  a player holds the answer slot
- grant_id  out  2  granted player
- time_left  out  7  remaining answer seconds
- question_no  out  4  questions completed
- scores  out  28  four 7-bit scores, player i at bits [7i+6:7i]
- game_over  out  1  game finished
- champion  out  2  winning player

Function
REQ-002 SHALL use states IDLE=0, OPEN=1, ANSWER=2, RESULT=3, WAIT=4, DONE=5.
REQ-003 SHALL, on start in IDLE or DONE, latch all six settings, clamp the latched player_count to 2..4, clear scores, question_no, game_over and champion, and enter OPEN.
REQ-004 SHALL ignore settings changes between start pulses.
REQ-005 SHALL treat a player as active only if index < latched player_count; inactive buzz bits are ignored.
REQ-006 SHALL, in OPEN, detect buzz rising edges (registered previous value) from active players and grant one of them the next cycle: grant_valid=1, grant_id set, time_left loaded with latched answer_time, state ANSWER.
REQ-007 SHALL resolve simultaneous rising edges round-robin, highest priority at (last grant_id + 1) mod 4; after reset, player 0 has highest priority.
REQ-008 SHALL ignore buzz edges in every state except OPEN, and held buttons do not retrigger.
REQ-009 SHALL, in ANSWER, decrement time_left on tick_1hz when it is nonzero; a tick_1hz with time_left=0 is a timeout, scored as a fail.
REQ-010 SHALL give judge_fail priority when judge_ok and judge_fail coincide; a verdict in the same cycle as a timeout tick takes precedence over the timeout.
REQ-011 SHALL, in RESULT (exactly one cycle), add success_score saturating at 127 or subtract fail_score flooring at 0 for grant_id, increment question_no and drop grant_valid.
REQ-012 SHALL leave RESULT for DONE if the updated score >= win_score (champion = grant_id) or question_no == question_count; otherwise it enters WAIT.
REQ-013 SHALL, on questions exhausted, set champion to the highest score, with ties going to the lowest index.
REQ-014 SHALL, in WAIT, enter OPEN on next; next in other states is ignored.
REQ-015 SHALL hold game_over=1 in DONE, and time_left=0 outside ANSWER.
REQ-016 SHALL treat latched question_count=0 as a one-question game.

Reset
REQ-017 SHALL, on rst, asynchronously set state=IDLE, grant_valid=0, grant_id=0, time_left=0, question_no=0, scores=0, game_over=0, champion=0, round-robin pointer=3 and buzz history=0.
REQ-018 SHALL return to IDLE on rst asserted mid-round, with no score update.

Structure
REQ-019 SHALL take the state encodings, score width (7) and max player count (4) from the shared game package.
REQ-020 SHALL place round-robin arbitration in sub-module rr_arbiter4: inputs req[3:0] and pointer; outputs gnt_id and gnt_valid; purely combinational.

Verification
REQ-021 Settings 2 players, answer_time 10, success 1, win 3; start, buzz[0] edge -> ANSWER with grant_id=0 and time_left=10; judge_ok -> scores[6:0]=1, state WAIT.
REQ-022 buzz=4'b1001 in the same cycle, first grant -> grant 0; repeated on the next question -> grant 3; buzz[3] with player_count=2 -> ignored.
REQ-023 Grant, then 11 ticks with no verdict -> timeout; score of 0 with fail 1 stays 0 (floor).
REQ-024 A player reaching win 3 -> DONE, game_over=1, champion=that player; a further next -> no change.
REQ-025 question_count=2 with scores ending 1,1 -> DONE, champion=0 (tie).
REQ-026 rst asserted in ANSWER -> all outputs at reset values within the same cycle.
